// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider among NUM_REQ requesters.
// Optional RUN watchdog enabled by defining DIV_ARB_TIMEOUT_EN.
module div_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_div,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   req_dividend,
    input  logic [32*NUM_REQ-1:0]   req_divisor,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      done,
    output logic [31:0]             res_quotient,
    output logic [31:0]             res_remainder,
    output logic                    res_err,
    output logic                    busy,
    output logic                    div_reset,
    output logic                    div_start,
    output logic [31:0]             div_dividend,
    output logic [31:0]             div_divisor,
    input  logic                    div_done,
    input  logic [31:0]             div_quotient,
    input  logic [31:0]             div_remainder
);
    localparam int PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("div_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, owner_q, win_idx;
    logic               win_vld;
    logic [NUM_REQ-1:0] grant_q;
    logic [31:0]        dvd_q, dvs_q, quot_q, rem_q;
    logic               err_q, div0, tmo_hit;
    logic [31:0]        dvd_a [NUM_REQ];
    logic [31:0]        dvs_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
        assign dvd_a[i] = req_dividend[32*i +: 32];
        assign dvs_a[i] = req_divisor[32*i +: 32];
    end

    assign div0 = (dvs_q == 32'd0);

    // First requesting index at or above ptr, wrapping past NUM_REQ-1.
    always_comb begin
        logic [PW:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
            if (!win_vld && req[cand[PW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[PW-1:0];
            end
        end
    end

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_q;

    always_ff @(posedge clk_div) begin
        if (!reset_n || state_q == S_LOAD) tmo_q <= '0;
        else if (state_q == S_RUN)         tmo_q <= tmo_q + 1'b1;
    end
    assign tmo_hit = (tmo_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_div) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (win_vld) state_d = S_LOAD;
            S_LOAD: state_d = div0 ? S_DONE : S_RUN;
            S_RUN:  if (div_done || tmo_hit) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        div_start = (state_q == S_RUN);
        div_reset = (state_q != S_RUN);
        done      = (state_q == S_DONE) ? grant_q : '0;
    end

    always_ff @(posedge clk_div) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (win_vld) begin
                    owner_q <= win_idx;
                    grant_q <= NUM_REQ'(1) << win_idx;
                    dvd_q   <= dvd_a[win_idx];
                    dvs_q   <= dvs_a[win_idx];
                end
                S_LOAD: if (div0) begin
                    quot_q <= 32'hFFFF_FFFF;
                    rem_q  <= dvd_q;
                    err_q  <= 1'b1;
                end
                S_RUN: if (div_done) begin
                    quot_q <= div_quotient;
                    rem_q  <= div_remainder;
                    err_q  <= 1'b0;
                end else if (tmo_hit) begin
                    quot_q <= '0;
                    rem_q  <= '0;
                    err_q  <= 1'b1;
                end
                S_DONE: begin
                    grant_q <= '0;
                    ptr_q   <= (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign grant         = grant_q;
    assign res_quotient  = quot_q;
    assign res_remainder = rem_q;
    assign res_err       = err_q;
    assign div_dividend  = dvd_q;
    assign div_divisor   = dvs_q;
endmodule
